// File: rtl/embertrail_pkg.sv
// Shared types and constants for the Embertrail fetch stage.
// Imported by every fetch-side RTL file.
package embertrail_pkg;

  localparam int HW_W = 16;
  localparam int IR_W = 32;

  localparam logic [HW_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_LO = 2'd0,
    FETCH_HI = 2'd1,
    VALID    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/embertrail_fetch.sv
// Embertrail instruction fetch: assembles {mem[pc+1], mem[pc]}
// from a 16-bit memory, reusing the upper halfword on pc+1.
module embertrail_fetch
  import embertrail_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iInstAddrBus,
  output logic [31:0] oIR,
  output logic [15:0] oPC,
  output logic        oIRValid,
  output logic        oIMemReq,
  output logic [15:0] oIMemAddr,
  input  logic [15:0] iIMemData,
  input  logic        iIMemAck
);

  fetch_state_e    state_q, state_d;
  logic [HW_W-1:0] tgt_q, tgt_d;
  logic [HW_W-1:0] lo_q, lo_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [HW_W-1:0] pc_q, pc_d;
  logic            redir_q, redir_d;

  logic            in_fetch;
  logic            bus_moved;
  logic            ack;
  logic [HW_W-1:0] tgt_inc;
  logic [HW_W-1:0] pc_inc;

  assign in_fetch  = (state_q == FETCH_LO)
                  || (state_q == FETCH_HI);
  assign bus_moved = (iInstAddrBus != tgt_q);
  assign ack       = iIMemAck && oIMemReq;
  assign tgt_inc   = tgt_q + 16'd1;
  assign pc_inc    = pc_q + 16'd1;

  // Request drops in the reset cycle itself so an
  // abandoned transaction never sees a stray ack.
  assign oIMemReq  = in_fetch && !iReset;
  assign oIMemAddr = (state_q == FETCH_HI) ? tgt_inc
                                           : tgt_q;
  assign oIRValid  = (state_q == VALID);
  assign oIR       = ir_q;
  assign oPC       = pc_q;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    lo_d    = lo_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    case (state_q)
      FETCH_LO: begin
        if (bus_moved) redir_d = 1'b1;
        if (ack) begin
          if (redir_q || bus_moved) begin
            tgt_d   = iInstAddrBus;
            redir_d = 1'b0;
          end else begin
            lo_d    = iIMemData;
            state_d = FETCH_HI;
          end
        end
      end
      FETCH_HI: begin
        if (bus_moved) redir_d = 1'b1;
        if (ack) begin
          if (redir_q || bus_moved) begin
            tgt_d   = iInstAddrBus;
            redir_d = 1'b0;
            state_d = FETCH_LO;
          end else begin
            ir_d    = {iIMemData, lo_q};
            pc_d    = tgt_q;
            state_d = VALID;
          end
        end
      end
      VALID: begin
        if (iInstAddrBus == pc_q) begin
          state_d = VALID;
        end else if (iInstAddrBus == pc_inc) begin
          lo_d    = ir_q[IR_W-1:HW_W];
          tgt_d   = iInstAddrBus;
          state_d = FETCH_HI;
        end else begin
          tgt_d   = iInstAddrBus;
          state_d = FETCH_LO;
        end
      end
      default: begin
        tgt_d   = iInstAddrBus;
        redir_d = 1'b0;
        state_d = FETCH_LO;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= FETCH_LO;
      tgt_q   <= RESET_PC;
      lo_q    <= '0;
      ir_q    <= '0;
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      lo_q    <= lo_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

endmodule
